// File: rtl/fetch_pc_unit_pkg.sv
// Shared decode defines for the fetch/PC unit: next-PC selector codes, ALU
// function codes, FSM state type and the target alignment helper.
package fetch_pc_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSN_BYTES = 32'd4;

  // Decoder next-PC selector; codes 4..7 are reserved and behave as PC+4.
  typedef enum logic [2:0] {
    PC_FROM_PC_PLUS_4 = 3'd0,
    PC_PLUS_JAL_IMM   = 3'd1,
    NEXT_PC_FROM_RF   = 3'd2,
    PC_PLUS_BRCH_IMM  = 3'd3
  } next_pc_sel_e;

  // ALU function codes shared with the decoder; BEQ resolves on AminusB == 0.
  typedef enum logic [3:0] {
    ALU_APLUSB  = 4'd0,
    ALU_AMINUSB = 4'd1
  } alu_func_e;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_e;

  // A target is unusable when bit 1 is set (not on a 4-byte boundary).
  function automatic logic addr_misaligned(input logic [XLEN-1:0] addr);
    return ((addr & 32'h0000_0002) != 32'h0000_0000);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response and decode-issue handshake bundle.
interface fetch_pc_unit_if;
  import fetch_pc_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_encoding;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output inst_valid,
    input  inst_ready,
    output inst_encoding,
    output inst_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  inst_valid,
    output inst_ready,
    input  inst_encoding,
    input  inst_pc
  );

endinterface

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// Combinational next-PC target selection and misalignment detection for the
// instruction currently being resolved.
module next_pc_calc
  import fetch_pc_unit_pkg::*;
(
  input  logic [2:0]      next_pc_sel_i,
  input  logic [XLEN-1:0] inst_pc_i,
  input  logic [XLEN-1:0] jal_imm_i,
  input  logic [XLEN-1:0] brch_imm_i,
  input  logic [XLEN-1:0] rf_target_i,
  input  logic            branch_taken_i,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] seq_pc_s;
  logic [XLEN-1:0] jal_pc_s;
  logic [XLEN-1:0] brch_pc_s;
  logic [XLEN-1:0] rf_pc_s;
  logic [XLEN-1:0] target_s;

  // All sums are plain 32-bit adds so they wrap modulo 2^32.
  assign seq_pc_s  = inst_pc_i + INSN_BYTES;
  assign jal_pc_s  = inst_pc_i + jal_imm_i;
  assign brch_pc_s = inst_pc_i + brch_imm_i;
  assign rf_pc_s   = rf_target_i & 32'hFFFF_FFFE;

  // Select the resolved target from the decoder selector.
  always_comb begin
    target_s = seq_pc_s;
    case (next_pc_sel_i)
      PC_FROM_PC_PLUS_4: target_s = seq_pc_s;
      PC_PLUS_JAL_IMM:   target_s = jal_pc_s;
      NEXT_PC_FROM_RF:   target_s = rf_pc_s;
      PC_PLUS_BRCH_IMM: begin
        if (branch_taken_i) begin
          target_s = brch_pc_s;
        end else begin
          target_s = seq_pc_s;
        end
      end
      default:           target_s = seq_pc_s;
    endcase
  end

  assign target_o   = target_s;
  assign misalign_o = addr_misaligned(target_s);

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch/PC unit: keeps one instruction in flight -- fetch it, offer it to
// decode, wait for its control outcome, then steer the PC to the next target.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_pc_unit_if.master   bus,
  input  logic              resolve_valid,
  input  logic [2:0]        next_pc_sel,
  input  logic [XLEN-1:0]   jal_imm,
  input  logic [XLEN-1:0]   brch_imm,
  input  logic [XLEN-1:0]   rf_target,
  input  logic              branch_taken,
  output logic              misalign_err,
  output logic [XLEN-1:0]   retire_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] enc_q, enc_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] retire_q, retire_d;

  logic [XLEN-1:0] target_s;
  logic            target_misaligned_s;

  next_pc_calc u_next_pc_calc (
    .next_pc_sel_i  (next_pc_sel),
    .inst_pc_i      (inst_pc_q),
    .jal_imm_i      (jal_imm),
    .brch_imm_i     (brch_imm),
    .rf_target_i    (rf_target),
    .branch_taken_i (branch_taken),
    .target_o       (target_s),
    .misalign_o     (target_misaligned_s)
  );

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      enc_q      <= 32'h0000_0000;
      inst_pc_q  <= 32'h0000_0000;
      misalign_q <= 1'b0;
      retire_q   <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      enc_q      <= enc_d;
      inst_pc_q  <= inst_pc_d;
      misalign_q <= misalign_d;
      retire_q   <= retire_d;
    end
  end

  // Next-state and next-output logic; req/valid are computed one cycle ahead
  // so both leave the block straight from flops.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = 1'b0;
    valid_d    = 1'b0;
    enc_d      = enc_q;
    inst_pc_d  = inst_pc_q;
    misalign_d = misalign_q;
    retire_d   = retire_q;
    case (state_q)
      ST_FETCH: begin
        // The first cycle out of reset has no request yet, so an ack there is stray.
        if (req_q && bus.imem_ack) begin
          enc_d     = bus.imem_rdata;
          inst_pc_d = pc_q;
          valid_d   = 1'b1;
          state_d   = ST_ISSUE;
        end else begin
          req_d     = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        if (bus.inst_ready) begin
          state_d = ST_RESOLVE;
        end else begin
          valid_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_RESOLVE: begin
        if (resolve_valid) begin
          retire_d = retire_q + 32'd1;
          if (target_misaligned_s) begin
            misalign_d = 1'b1;
            state_d    = ST_HALT;
          end else begin
            pc_d    = target_s;
            req_d   = 1'b1;
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_RESOLVE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  assign bus.imem_req      = req_q;
  assign bus.imem_addr     = pc_q;
  assign bus.inst_valid    = valid_q;
  assign bus.inst_encoding = enc_q;
  assign bus.inst_pc       = inst_pc_q;
  assign misalign_err      = misalign_q;
  assign retire_count      = retire_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: two instances in lockstep, one with the
// default RESET_PC and one with RESET_PC = 32'h8000_0000.
module tb_fetch_pc_unit;
  import fetch_pc_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        resolve_valid;
  logic [2:0]  next_pc_sel;
  logic [31:0] jal_imm, brch_imm, rf_target;
  logic        branch_taken;
  logic        misalign_err0, misalign_err1;
  logic [31:0] retire_count0, retire_count1;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];
  logic [31:0] exp_retire;

  fetch_pc_unit_if bus0();
  fetch_pc_unit_if bus1();

  always #5 clk = ~clk;

  assign bus1.imem_ack   = bus0.imem_ack;
  assign bus1.imem_rdata = bus0.imem_rdata;
  assign bus1.inst_ready = bus0.inst_ready;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .resolve_valid(resolve_valid),
    .next_pc_sel(next_pc_sel), .jal_imm(jal_imm), .brch_imm(brch_imm),
    .rf_target(rf_target), .branch_taken(branch_taken),
    .misalign_err(misalign_err0), .retire_count(retire_count0)
  );

  fetch_pc_unit #(.RESET_PC(32'h8000_0000)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .resolve_valid(resolve_valid),
    .next_pc_sel(next_pc_sel), .jal_imm(jal_imm), .brch_imm(brch_imm),
    .rf_target(rf_target), .branch_taken(branch_taken),
    .misalign_err(misalign_err1), .retire_count(retire_count1)
  );

  task automatic restart_scoreboard();
    exp_addr_q.delete();
    exp_inst_q.delete();
    exp_addr_q.push_back(32'h0000_0000);
    exp_retire = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; resolve_valid = 1'b0; next_pc_sel = 3'd0;
    jal_imm = 32'd0; brch_imm = 32'd0; rf_target = 32'd0; branch_taken = 1'b0;
    bus0.imem_ack = 1'b0; bus0.imem_rdata = 32'd0; bus0.inst_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus0.imem_req, bus0.inst_valid, misalign_err0} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000", {bus0.imem_req, bus0.inst_valid, misalign_err0});
    end
    checks++;
    if ({bus0.inst_encoding, bus0.inst_pc, retire_count0} !== 96'd0) begin
      failures++; $display("FAIL reset_regs got=%h %h %h exp=0", bus0.inst_encoding, bus0.inst_pc, retire_count0);
    end
    checks++;
    if (bus0.imem_addr !== 32'h0000_0000 || bus1.imem_addr !== 32'h8000_0000) begin
      failures++; $display("FAIL reset_addr got=%h %h exp=00000000 80000000", bus0.imem_addr, bus1.imem_addr);
    end
    rst_n = 1'b1;
    restart_scoreboard();
    #1;
    checks++;
    if (bus0.imem_req !== 1'b0) begin
      failures++; $display("FAIL req_before_edge got=%b exp=0", bus0.imem_req);
    end
  endtask

  task automatic fetch(input logic [31:0] word);
    logic [31:0] a;
    logic [63:0] e;
    int n;
    n = 0;
    while (bus0.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus0.imem_req !== 1'b1) begin
      failures++; $display("FAIL fetch_req_timeout got=%b exp=1", bus0.imem_req);
      return;
    end
    a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hxxxx_xxxx;
    checks++;
    if (bus0.imem_addr !== a) begin
      failures++; $display("FAIL fetch_addr got=%h exp=%h", bus0.imem_addr, a);
    end
    exp_inst_q.push_back({word, a});
    bus0.imem_ack = 1'b1; bus0.imem_rdata = word;
    @(negedge clk);
    bus0.imem_ack = 1'b0; bus0.imem_rdata = 32'd0;
    checks++;
    if ({bus0.inst_valid, bus0.imem_req} !== 2'b10) begin
      failures++; $display("FAIL issue_valid got=%b exp=10", {bus0.inst_valid, bus0.imem_req});
    end
    e = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : 64'hx;
    checks++;
    if ({bus0.inst_encoding, bus0.inst_pc} !== e) begin
      failures++; $display("FAIL issue_data got=%h %h exp=%h", bus0.inst_encoding, bus0.inst_pc, e);
    end
  endtask

  task automatic accept();
    bus0.inst_ready = 1'b1;
    @(negedge clk);
    bus0.inst_ready = 1'b0;
    checks++;
    if ({bus0.inst_valid, bus0.imem_req} !== 2'b00) begin
      failures++; $display("FAIL accept_idle got=%b exp=00", {bus0.inst_valid, bus0.imem_req});
    end
  endtask

  task automatic resolve(input logic [2:0] sel, input logic [31:0] jal, input logic [31:0] brch,
                         input logic [31:0] rf, input logic taken, input logic [31:0] exp_target);
    next_pc_sel = sel; jal_imm = jal; brch_imm = brch; rf_target = rf; branch_taken = taken;
    resolve_valid = 1'b1;
    exp_addr_q.push_back(exp_target);
    exp_retire = exp_retire + 32'd1;
    @(negedge clk);
    resolve_valid = 1'b0;
    checks++;
    if (bus0.imem_req !== 1'b1) begin
      failures++; $display("FAIL resolve_req got=%b exp=1", bus0.imem_req);
    end
    checks++;
    if (retire_count0 !== exp_retire) begin
      failures++; $display("FAIL retire_count got=%h exp=%h", retire_count0, exp_retire);
    end
  endtask

  task automatic run_instr(input logic [31:0] word, input logic [2:0] sel, input logic [31:0] jal,
                           input logic [31:0] brch, input logic [31:0] rf, input logic taken,
                           input logic [31:0] exp_target);
    fetch(word);
    accept();
    resolve(sel, jal, brch, rf, taken, exp_target);
  endtask

  task automatic test_sequential();
    run_instr(32'h0000_0013, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'h0000_0004);
    checks++;
    if (bus1.imem_addr !== 32'h8000_0004 || retire_count1 !== 32'd1) begin
      failures++; $display("FAIL dut1_seq got=%h %h exp=80000004 1", bus1.imem_addr, retire_count1);
    end
    run_instr(32'h0000_8067, 3'd2, 32'd0, 32'd0, 32'h0000_0101, 1'b0, 32'h0000_0100);
  endtask

  task automatic test_jal();
    run_instr(32'hFF1F_F06F, 3'd1, 32'hFFFF_FFF0, 32'd0, 32'd0, 1'b0, 32'h0000_00F0);
  endtask

  task automatic test_branch();
    run_instr(32'h0000_8067, 3'd2, 32'd0, 32'd0, 32'h0000_0040, 1'b0, 32'h0000_0040);
    run_instr(32'h0200_0063, 3'd3, 32'd0, 32'h0000_0020, 32'd0, 1'b1, 32'h0000_0060);
    run_instr(32'h0000_8067, 3'd2, 32'd0, 32'd0, 32'h0000_0040, 1'b0, 32'h0000_0040);
    run_instr(32'h0200_0063, 3'd3, 32'd0, 32'h0000_0020, 32'd0, 1'b0, 32'h0000_0044);
    run_instr(32'h0000_0013, 3'd5, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 1'b1, 32'h0000_0048);
  endtask

  task automatic test_wrap();
    run_instr(32'h0000_8067, 3'd2, 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);
    run_instr(32'h0000_0013, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'h0000_0000);
  endtask

  task automatic test_stall();
    fetch(32'h0000_0033);
    for (int i = 0; i < 5; i++) begin
      bus0.imem_ack = (i == 1); bus0.imem_rdata = 32'hDEAD_BEEF;
      resolve_valid = (i == 2); next_pc_sel = 3'd0;
      @(negedge clk);
      checks++;
      if ({bus0.inst_encoding, bus0.inst_pc} !== {32'h0000_0033, 32'h0000_0000} ||
          {bus0.inst_valid, bus0.imem_req} !== 2'b10) begin
        failures++; $display("FAIL stall_cycle%0d got=%h %h %b exp=00000033 00000000 10", i,
                             bus0.inst_encoding, bus0.inst_pc, {bus0.inst_valid, bus0.imem_req});
      end
    end
    bus0.imem_ack = 1'b0; resolve_valid = 1'b0;
    accept();
    bus0.imem_ack = 1'b1; bus0.imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus0.imem_ack = 1'b0;
    checks++;
    if ({bus0.inst_valid, bus0.imem_req} !== 2'b00 || bus0.inst_encoding !== 32'h0000_0033 ||
        retire_count0 !== exp_retire) begin
      failures++; $display("FAIL stray_in_resolve got=%b %h %h exp=00 00000033 %h",
                           {bus0.inst_valid, bus0.imem_req}, bus0.inst_encoding, retire_count0, exp_retire);
    end
    resolve(3'd2, 32'd0, 32'd0, 32'h0000_0201, 1'b0, 32'h0000_0200);
  endtask

  task automatic test_misalign();
    fetch(32'h0000_8067);
    accept();
    next_pc_sel = 3'd2; rf_target = 32'h0000_0203; resolve_valid = 1'b1;
    exp_retire = exp_retire + 32'd1;
    @(negedge clk);
    resolve_valid = 1'b0;
    checks++;
    if ({misalign_err0, bus0.imem_req, bus0.inst_valid} !== 3'b100 || bus0.imem_addr !== 32'h0000_0200 ||
        retire_count0 !== exp_retire) begin
      failures++; $display("FAIL misalign_enter got=%b %h %h exp=100 00000200 %h",
                           {misalign_err0, bus0.imem_req, bus0.inst_valid}, bus0.imem_addr, retire_count0, exp_retire);
    end
    for (int i = 0; i < 6; i++) begin
      bus0.imem_ack = i[0]; resolve_valid = ~i[0]; next_pc_sel = 3'd0;
      @(negedge clk);
      checks++;
      if ({misalign_err0, bus0.imem_req, bus0.inst_valid} !== 3'b100 || bus0.imem_addr !== 32'h0000_0200 ||
          retire_count0 !== exp_retire) begin
        failures++; $display("FAIL halt_cycle%0d got=%b %h %h exp=100 00000200 %h", i,
                             {misalign_err0, bus0.imem_req, bus0.inst_valid}, bus0.imem_addr, retire_count0, exp_retire);
      end
    end
    bus0.imem_ack = 1'b0; resolve_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus0.imem_req, bus0.inst_valid, misalign_err0} !== 3'b000 || retire_count0 !== 32'd0 ||
        bus0.imem_addr !== 32'h0000_0000 || bus1.imem_addr !== 32'h8000_0000 || retire_count1 !== 32'd0) begin
      failures++; $display("FAIL reset_from_halt got=%b %h %h %h %h exp=000 0 0 80000000 0",
                           {bus0.imem_req, bus0.inst_valid, misalign_err0}, retire_count0,
                           bus0.imem_addr, bus1.imem_addr, retire_count1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    restart_scoreboard();
    @(negedge clk);
    checks++;
    if (bus0.imem_req !== 1'b1) begin
      failures++; $display("FAIL req_after_reset got=%b exp=1", bus0.imem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus0.imem_req !== 1'b0 || bus1.imem_addr !== 32'h8000_0000 || retire_count1 !== 32'd0) begin
      failures++; $display("FAIL reset_in_fetch got=%b %h %h exp=0 80000000 0", bus0.imem_req, bus1.imem_addr, retire_count1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(32'h0000_0013, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'h0000_0004);
    checks++;
    if (bus1.imem_addr !== 32'h8000_0004 || retire_count1 !== 32'd1) begin
      failures++; $display("FAIL dut1_after_reset got=%h %h exp=80000004 1", bus1.imem_addr, retire_count1);
    end
    fetch(32'h0000_0093);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus0.inst_valid, bus0.inst_encoding, bus0.inst_pc, retire_count0} !== 97'd0) begin
      failures++; $display("FAIL reset_in_issue got=%b %h %h %h exp=0 0 0 0", bus0.inst_valid,
                           bus0.inst_encoding, bus0.inst_pc, retire_count0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h0000_0000 || retire_count0 !== 32'd0) begin
      failures++; $display("FAIL restart_fetch got=%b %h %h exp=1 0 0", bus0.imem_req, bus0.imem_addr, retire_count0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_jal();
    test_branch();
    test_wrap();
    test_stall();
    test_misalign();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
